// File: rtl/ddr3_stream_tester.sv
// DDR3 AXI-Stream FIFO self-test sequencer: writes BURST_LEN pattern words, reads them back and checks them.
// Build option: define DDR3_TEST_LFSR_EN for a 16-bit LFSR pattern instead of the incrementing pattern.
module ddr3_stream_tester #(
  parameter int                DATA_W    = 16,
  parameter int                BURST_LEN = 1024,
  parameter logic [DATA_W-1:0] SEED      = 'h0001,
  parameter int                TIMEOUT   = 65535,
  parameter int                LOOP      = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  output logic              wr_tvalid,
  input  logic              wr_tready,
  output logic [DATA_W-1:0] wr_tdata,
  input  logic              rd_tvalid,
  output logic              rd_tready,
  input  logic [DATA_W-1:0] rd_tdata,
  output logic              test_done,
  output logic              test_pass,
  output logic              test_fail,
  output logic              timeout_flag,
  output logic [15:0]       err_cnt,
  output logic [15:0]       pass_cnt,
  output logic [3:0]        state_o
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_WRITE = 4'b0010,
    S_READ  = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);
  localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_exp;
  logic [15:0]       r_wr_cnt;
  logic [15:0]       r_rd_cnt;
  logic [15:0]       r_idle_cnt;
  logic [15:0]       r_err_cnt;
  logic [15:0]       r_pass_cnt;
  logic              r_timeout;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;

  logic              w_wr_beat;
  logic              w_rd_beat;
  logic              w_abort;
  logic              w_restart;
  logic              w_timeout;
  logic              w_read_entry;
  logic              w_done_entry;
  logic [15:0]       w_idle_nxt;
  logic [15:0]       w_err_nxt;

  function automatic logic [DATA_W-1:0] f_next(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] n;
`ifdef DDR3_TEST_LFSR_EN
    n       = d;
    n[15:0] = {d[14:0], d[15] ^ d[13] ^ d[12] ^ d[10]};
`else
    n = d + DATA_W'(1);
`endif
    return n;
  endfunction

  // Handshake: a beat is tvalid & tready at a rising edge. wr_tvalid is held
  // for the whole WRITE state and wr_tdata only moves on a beat, so data is
  // stable under back-pressure; rd_tready is high for every READ cycle.
  assign wr_tvalid    = (r_state == S_WRITE);
  assign rd_tready    = (r_state == S_READ);
  assign wr_tdata     = r_wr_data;
  assign test_done    = r_done;
  assign test_pass    = r_pass;
  assign test_fail    = r_fail;
  assign timeout_flag = r_timeout;
  assign err_cnt      = r_err_cnt;
  assign pass_cnt     = r_pass_cnt;
  assign state_o      = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_beat   = 1'b0;
    w_rd_beat   = 1'b0;
    w_abort     = 1'b0;
    w_restart   = 1'b0;
    w_timeout   = 1'b0;
    w_idle_nxt  = r_idle_cnt;
    w_err_nxt   = r_err_cnt;
    case (r_state)
      S_IDLE: begin
        if (init_calib_complete) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (!init_calib_complete) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (wr_tready) begin
          w_wr_beat = 1'b1;
          if (r_wr_cnt == LAST_IDX) w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (!init_calib_complete) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (rd_tvalid) begin
          w_rd_beat  = 1'b1;
          w_idle_nxt = 16'd0;
          if ((rd_tdata != r_exp) && (r_err_cnt != 16'hFFFF)) w_err_nxt = r_err_cnt + 16'd1;
          if (r_rd_cnt == LAST_IDX) w_state_nxt = S_DONE;
        end else begin
          w_idle_nxt = r_idle_cnt + 16'd1;
          if (w_idle_nxt == IDLE_MAX) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Calibration status is deliberately ignored once the verdict is latched.
        if ((LOOP != 0) && r_pass) begin
          w_restart   = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_read_entry = (r_state == S_WRITE) && (w_state_nxt == S_READ);
  assign w_done_entry = (r_state != S_DONE) && (w_state_nxt == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_data  <= SEED;
      r_exp      <= SEED;
      r_wr_cnt   <= 16'd0;
      r_rd_cnt   <= 16'd0;
      r_idle_cnt <= 16'd0;
      r_err_cnt  <= 16'd0;
      r_pass_cnt <= 16'd0;
      r_timeout  <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
    end else if (w_abort || w_restart) begin
      // Abort and loop restart both start a clean pass; only pass_cnt survives.
      r_wr_data  <= SEED;
      r_exp      <= SEED;
      r_wr_cnt   <= 16'd0;
      r_rd_cnt   <= 16'd0;
      r_idle_cnt <= 16'd0;
      r_err_cnt  <= 16'd0;
      r_timeout  <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      if (w_restart) r_pass_cnt <= r_pass_cnt + 16'd1;
    end else begin
      if (w_wr_beat) begin
        r_wr_data <= f_next(r_wr_data);
        r_wr_cnt  <= r_wr_cnt + 16'd1;
      end
      if (w_read_entry) begin
        r_exp      <= SEED;
        r_idle_cnt <= 16'd0;
      end
      if (w_rd_beat) begin
        r_exp    <= f_next(r_exp);
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (r_state == S_READ) r_idle_cnt <= w_idle_nxt;
      r_err_cnt <= w_err_nxt;
      if (w_timeout) r_timeout <= 1'b1;
      if (w_done_entry) begin
        r_done <= 1'b1;
        r_pass <= (w_err_nxt == 16'd0) && !w_timeout;
        r_fail <= !((w_err_nxt == 16'd0) && !w_timeout);
      end
    end
  end

endmodule

// File: tb/tb_ddr3_stream_tester.sv
// Directed bench for ddr3_stream_tester: loopback stream model with a scoreboard of expected write words.
module tb_ddr3_stream_tester;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         a_calib, a_wr_tvalid, a_wr_tready, a_rd_tvalid, a_rd_tready;
  logic         a_test_done, a_test_pass, a_test_fail, a_timeout_flag;
  logic [W-1:0] a_wr_tdata, a_rd_tdata;
  logic [15:0]  a_err_cnt, a_pass_cnt;
  logic [3:0]   a_state;

  logic         b_calib, b_wr_tvalid, b_wr_tready, b_rd_tvalid, b_rd_tready;
  logic         b_test_done, b_test_pass, b_test_fail, b_timeout_flag;
  logic [W-1:0] b_wr_tdata, b_rd_tdata;
  logic [15:0]  b_err_cnt, b_pass_cnt;
  logic [3:0]   b_state;

  ddr3_stream_tester #(.DATA_W(16), .BURST_LEN(8), .SEED(16'h0001), .TIMEOUT(100), .LOOP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(a_calib),
    .wr_tvalid(a_wr_tvalid), .wr_tready(a_wr_tready), .wr_tdata(a_wr_tdata),
    .rd_tvalid(a_rd_tvalid), .rd_tready(a_rd_tready), .rd_tdata(a_rd_tdata),
    .test_done(a_test_done), .test_pass(a_test_pass), .test_fail(a_test_fail),
    .timeout_flag(a_timeout_flag), .err_cnt(a_err_cnt), .pass_cnt(a_pass_cnt), .state_o(a_state)
  );

  ddr3_stream_tester #(.DATA_W(16), .BURST_LEN(4), .SEED(16'hFFFE), .TIMEOUT(65535), .LOOP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(b_calib),
    .wr_tvalid(b_wr_tvalid), .wr_tready(b_wr_tready), .wr_tdata(b_wr_tdata),
    .rd_tvalid(b_rd_tvalid), .rd_tready(b_rd_tready), .rd_tdata(b_rd_tdata),
    .test_done(b_test_done), .test_pass(b_test_pass), .test_fail(b_test_fail),
    .timeout_flag(b_timeout_flag), .err_cnt(b_err_cnt), .pass_cnt(b_pass_cnt), .state_o(b_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] loop_q[$];
  logic [W-1:0] b_exp_q[$];
  logic [W-1:0] b_loop_q[$];
  logic [15:0]  pc_q[$];

  int           cyc, wr_beats, rd_beats, rd_idx, corrupt_idx, n;
  int           rd_entry, to_at;
  bit           stall_en, return_en, prev_hold;
  logic [W-1:0] prev_data;
  logic [15:0]  b_last_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] seed, input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(seed + 16'(i));
  endtask

  task automatic model_clear();
    exp_q.delete();
    loop_q.delete();
    wr_beats  = 0;
    rd_beats  = 0;
    rd_idx    = 0;
    prev_hold = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    a_calib     = 1'b0;
    a_wr_tready = 1'b0;
    a_rd_tvalid = 1'b0;
    a_rd_tdata  = '0;
    b_calib     = 1'b0;
    b_wr_tready = 1'b0;
    b_rd_tvalid = 1'b0;
    b_rd_tdata  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One cycle of the loopback model for instance A: drive at the falling edge,
  // then score the beats that the next rising edge will accept.
  task automatic tick_a(input logic calib);
    @(negedge clk);
    cyc++;
    a_calib     = calib;
    a_wr_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (return_en && loop_q.size() > 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
      a_rd_tvalid = 1'b1;
      a_rd_tdata  = loop_q[0] ^ ((rd_idx == corrupt_idx) ? 16'h0004 : 16'h0000);
    end else begin
      a_rd_tvalid = 1'b0;
      a_rd_tdata  = 16'($urandom);
    end
    #1;
    if (prev_hold && a_wr_tvalid) chk("wr_hold", a_wr_tdata, prev_data);
    prev_hold = a_wr_tvalid && !a_wr_tready;
    prev_data = a_wr_tdata;
    if (a_wr_tvalid && a_wr_tready && calib) begin
      if (exp_q.size() > 0) chk("wr_data", a_wr_tdata, exp_q.pop_front());
      else                  chk("wr_extra_beat", exp_q.size(), 1);
      loop_q.push_back(a_wr_tdata);
      wr_beats++;
    end
    if (a_rd_tvalid && a_rd_tready && calib) begin
      void'(loop_q.pop_front());
      rd_beats++;
      rd_idx++;
    end
  endtask

  task automatic run_a(input int budget);
    int k;
    k = 0;
    while (!a_test_done && k < budget) begin
      tick_a(1'b1);
      k++;
    end
    chk("run_a_budget", a_test_done, 1);
  endtask

  task automatic tick_b();
    @(negedge clk);
    b_calib     = 1'b1;
    b_wr_tready = 1'b1;
    if (b_loop_q.size() > 0) begin
      b_rd_tvalid = 1'b1;
      b_rd_tdata  = b_loop_q[0];
    end else begin
      b_rd_tvalid = 1'b0;
      b_rd_tdata  = 16'($urandom);
    end
    #1;
    if (b_wr_tvalid) begin
      if (b_exp_q.size() > 0) chk("b_wr_data", b_wr_tdata, b_exp_q.pop_front());
      else                    chk("b_wr_extra_beat", b_exp_q.size(), 1);
      b_loop_q.push_back(b_wr_tdata);
    end
    if (b_rd_tvalid && b_rd_tready) void'(b_loop_q.pop_front());
    if (b_test_done) begin
      chk("b_test_pass", b_test_pass, 1);
      chk("b_err_cnt", b_err_cnt, 0);
    end
    if (b_pass_cnt !== b_last_pc) begin
      if (pc_q.size() > 0) chk("b_pass_cnt", b_pass_cnt, pc_q.pop_front());
      b_last_pc = b_pass_cnt;
    end
  endtask

  initial begin
    stall_en    = 1'b0;
    return_en   = 1'b1;
    corrupt_idx = -1;
    cyc         = 0;
    b_last_pc   = 16'd0;
    rst_n       = 1'b0;
    do_reset();
    #1;
    chk("rst_state", a_state, 4'b0001);
    chk("rst_wr_tvalid", a_wr_tvalid, 0);
    chk("rst_rd_tready", a_rd_tready, 0);
    chk("rst_wr_tdata", a_wr_tdata, 16'h0001);
    chk("rst_flags", {a_test_done, a_test_pass, a_test_fail, a_timeout_flag}, 4'b0000);
    chk("rst_err_cnt", a_err_cnt, 0);
    chk("rst_pass_cnt", a_pass_cnt, 0);
    chk("rst_b_wr_tdata", b_wr_tdata, 16'hFFFE);
    chk("rst_b_state", b_state, 4'b0001);

    // Plain loopback, calibration arrives around cycle 10.
    repeat (9) tick_a(1'b0);
    chk("idle_wait_state", a_state, 4'b0001);
    chk("idle_wait_valid", a_wr_tvalid, 0);
    push_exp(16'h0001, 8);
    tick_a(1'b1);
    tick_a(1'b1);
    chk("write_entry_state", a_state, 4'b0010);
    chk("write_entry_valid", a_wr_tvalid, 1);
    run_a(200);
    chk("t1_state", a_state, 4'b1000);
    chk("t1_pass", {a_test_pass, a_test_fail}, 2'b10);
    chk("t1_err_cnt", a_err_cnt, 0);
    chk("t1_wr_beats", wr_beats, 8);
    chk("t1_rd_beats", rd_beats, 8);

    // Word index 3 corrupted on the way back.
    do_reset();
    corrupt_idx = 3;
    push_exp(16'h0001, 8);
    run_a(200);
    corrupt_idx = -1;
    chk("t2_err_cnt", a_err_cnt, 1);
    chk("t2_fail", {a_test_pass, a_test_fail}, 2'b01);
    chk("t2_timeout", a_timeout_flag, 0);

    // Random back-pressure on both streams.
    do_reset();
    stall_en = 1'b1;
    push_exp(16'h0001, 8);
    run_a(400);
    repeat (5) tick_a(1'b1);
    stall_en = 1'b0;
    chk("t3_wr_beats", wr_beats, 8);
    chk("t3_rd_beats", rd_beats, 8);
    chk("t3_pass", {a_test_pass, a_test_fail}, 2'b10);
    chk("t3_exp_left", exp_q.size(), 0);

    // Read stream never answers.
    do_reset();
    return_en = 1'b0;
    push_exp(16'h0001, 8);
    rd_entry = -1;
    to_at    = -1;
    n        = 0;
    while (!a_timeout_flag && n < 400) begin
      tick_a(1'b1);
      if (a_state == 4'b0100 && rd_entry < 0) rd_entry = cyc;
      n++;
    end
    if (a_timeout_flag) to_at = cyc;
    return_en = 1'b1;
    chk("t4_timeout_flag", a_timeout_flag, 1);
    chk("t4_timeout_latency", to_at - rd_entry, 100);
    chk("t4_fail", {a_test_pass, a_test_fail}, 2'b01);
    chk("t4_state", a_state, 4'b1000);
    chk("t4_rd_beats", rd_beats, 0);

    // Calibration lost after the fourth write beat, then restored.
    do_reset();
    push_exp(16'h0001, 8);
    n = 0;
    while (wr_beats < 4 && n < 100) begin
      tick_a(1'b1);
      n++;
    end
    tick_a(1'b0);
    tick_a(1'b0);
    chk("t5_abort_state", a_state, 4'b0001);
    chk("t5_abort_valid", a_wr_tvalid, 0);
    chk("t5_abort_ready", a_rd_tready, 0);
    chk("t5_abort_done", a_test_done, 0);
    model_clear();
    push_exp(16'h0001, 8);
    run_a(200);
    chk("t5_rerun_pass", {a_test_pass, a_test_fail}, 2'b10);
    chk("t5_rerun_wr_beats", wr_beats, 8);
    chk("t5_rerun_err", a_err_cnt, 0);

    // Looping instance with a wrapping seed.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      b_exp_q.push_back(16'hFFFE);
      b_exp_q.push_back(16'hFFFF);
      b_exp_q.push_back(16'h0000);
      b_exp_q.push_back(16'h0001);
    end
    pc_q.push_back(16'd1);
    pc_q.push_back(16'd2);
    pc_q.push_back(16'd3);
    b_last_pc = 16'd0;
    n = 0;
    while (pc_q.size() > 0 && n < 400) begin
      tick_b();
      n++;
    end
    chk("t6_runs_done", pc_q.size(), 0);
    chk("t6_pass_cnt", b_pass_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_stream_tester.md
Name: ddr3_stream_tester

Overview:
- Self-checking traffic sequencer for the DDR3 AXI-Stream FIFO wrapper.
- After DDR3 calibration it pushes BURST_LEN pattern words into the wrapper's write stream, then drains the same number from the read stream.
- Each returned word is compared against a regenerated expected pattern.
- Drives the board pass/fail LEDs and exposes an error count and state for debug.

Parameters:
- DATA_W, 16, stream data width (matches DDR3 wrapper stream width).
- BURST_LEN, 1024, words written and then read per pass; legal range 1..65535.
- SEED, 16'h0001, first pattern word; must be non-zero.
- TIMEOUT, 65535, max idle cycles in READ with no accepted beat before the pass is declared failed.
- LOOP, 0, 0 = single pass then hold in DONE; 1 = restart WRITE after each passing run.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- init_calib_complete  in  1  DDR3 calibration done, from the wrapper.
- wr_tvalid  out  1  write-stream valid to wrapper slave.
- wr_tready  in  1  write-stream ready from wrapper.
- wr_tdata  out  DATA_W  write-stream data.
- rd_tvalid  in  1  read-stream valid from wrapper master.
- rd_tready  out  1  read-stream ready to wrapper.
- rd_tdata  in  DATA_W  read-stream data.
- test_done  out  1  current pass finished (pass or fail).
- test_pass  out  1  done with zero errors and no timeout.
- test_fail  out  1  done with errors or timeout.
- timeout_flag  out  1  READ timed out.
- err_cnt  out  16  mismatching read beats; saturates at 16'hFFFF.
- pass_cnt  out  16  completed passing runs; wraps.
- state_o  out  4  one-hot state: IDLE=0001, WRITE=0010, READ=0100, DONE=1000.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all outputs 0.
  - wr_tdata=SEED; write/read counters 0; both pattern generators loaded with SEED.
- IDLE:
  - wr_tvalid=0, rd_tready=0.
  - When init_calib_complete=1, go to WRITE on the next cycle.
- WRITE:
  - wr_tvalid=1 from the first WRITE cycle.
  - A beat is wr_tvalid&wr_tready. On each beat, wr_tdata advances to the next pattern word and wr_cnt increments.
  - wr_tdata is stable while wr_tvalid=1 and wr_tready=0.
  - On the beat where wr_cnt==BURST_LEN-1: deassert wr_tvalid next cycle and go to READ. No extra beat is ever issued.
  - rd_tready=0, so no read beats are accepted.
- READ:
  - rd_tready=1 every READ cycle.
  - The expected generator is reloaded with SEED on READ entry.
  - A beat is rd_tvalid&rd_tready. On each beat, compare rd_tdata with the expected word; on mismatch err_cnt+1 (saturating). Advance the expected word; rd_cnt+1.
  - Idle counter clears on each beat, otherwise increments. If it reaches TIMEOUT: set timeout_flag, go to DONE.
  - On the beat where rd_cnt==BURST_LEN-1: rd_tready=0 next cycle, go to DONE.
- DONE:
  - test_done=1; test_pass=(err_cnt==0)&!timeout_flag; test_fail=!test_pass. Outputs are registered and update on the DONE entry cycle.
  - LOOP=1 and passing: pass_cnt+1, clear counters and flags, reload SEED, return to WRITE the next cycle.
  - Otherwise hold in DONE until reset.
- Pattern (default): next = current + 1, modulo 2^DATA_W; wraps 16'hFFFF -> 16'h0000.
- Calibration loss: init_calib_complete falling in WRITE or READ aborts to IDLE next cycle.
  - Deassert wr_tvalid/rd_tready; clear counters, err_cnt and flags; keep pass_cnt.
  - A beat accepted in the abort cycle is ignored.
  - DONE ignores init_calib_complete.
- Reset mid-operation returns immediately to the reset state; no partial-state retention.

Optional Feature:
- Macro: DDR3_TEST_LFSR_EN
- Defined: both generators use a 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0. The sequence starts at SEED.
- Not defined: incrementing pattern as above.
- Stream handshake and state timing are identical in both builds.

Test Plan:
- Loopback model (read stream replays written words, always ready), BURST_LEN=8, calib high at cycle 10 -> wr_tdata 0001..0008; state DONE; test_pass=1, err_cnt=0.
- Same, with the model corrupting word 3 (XOR 16'h0004) -> err_cnt=1, test_fail=1, test_pass=0.
- Random wr_tready/rd_tvalid stalls (50% duty) -> exactly 8 write beats, each value held across stalls; pass.
- Model never returns data, TIMEOUT=100 -> timeout_flag=1 and test_fail=1 exactly 100 idle READ cycles after READ entry.
- init_calib_complete dropped after write beat 4 -> IDLE next cycle, wr_tvalid=0; calib restored -> full rerun from SEED, pass.
- LOOP=1, SEED=16'hFFFE, BURST_LEN=4 -> data FFFE, FFFF, 0000, 0001; pass_cnt increments once per run (1, 2, 3).
